multi_digit_sensor_display: RTL and testbench

MULTI_DIGIT_SENSOR_DISPLAY -- requirements
Module: multi_digit_sensor_display

---
 rtl/sensor_display_pkg.sv | 42 ++++
 rtl/bin_to_bcd_seq.sv | 89 ++++++++
 rtl/multi_digit_sensor_display.sv | 127 ++++++++++++
 tb/tb_multi_digit_sensor_display.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_display_pkg.sv
// Shared definitions for the multi-digit sensor display: conversion FSM
// states, active-low seven-segment patterns (gfedcba) and the BCD decoder.
package sensor_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } conv_state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start, din   load strobe and binary operand (accepted only when idle)
//   busy         high from the accepting edge until the commit edge
//   done         high for the COMMIT cycle; bcd/ovf are final while high
//   bcd          N_DIGITS low nibbles of the working register
//   ovf          result does not fit in N_DIGITS decimal digits
module bin_to_bcd_seq
  import sensor_display_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int BIN_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      din,
  output logic                  busy,
  output logic                  done,
  output logic [N_DIGITS*4-1:0] bcd,
  output logic                  ovf
);

  localparam int WORK_W = (N_DIGITS + 1) * 4;
  localparam int CNT_W  = $clog2(BIN_W);

  conv_state_t       state;
  logic [WORK_W-1:0] work;
  logic [WORK_W-1:0] work_adj;
  logic [BIN_W-1:0]  bin_sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic              sticky;

  // Add-3 pass on every nibble that is 5 or more, ahead of the shift.
  always_comb begin
    work_adj = work;
    for (int unsigned i = 0; i < N_DIGITS + 1; i++) begin
      if (work[i*4 +: 4] >= 4'd5)
        work_adj[i*4 +: 4] = work[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      work    <= '0;
      bin_sr  <= '0;
      bit_cnt <= '0;
      sticky  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr  <= din;
            work    <= '0;
            bit_cnt <= '0;
            sticky  <= 1'b0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          work    <= {work_adj[WORK_W-2:0], bin_sr[BIN_W-1]};
          bin_sr  <= {bin_sr[BIN_W-2:0], 1'b0};
          // A bit pushed out of the top nibble means the value is far past range.
          sticky  <= sticky | work_adj[WORK_W-1];
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(BIN_W - 1)) begin
            done  <= 1'b1;
            state <= COMMIT;
          end
        end
        COMMIT: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bcd = work[N_DIGITS*4-1:0];
  assign ovf = sticky | (work[WORK_W-1 -: 4] != 4'd0);

endmodule

// File: rtl/multi_digit_sensor_display.sv
// Multiplexed seven-segment display of an unsigned sensor value.
// Ports:
//   fpga_clk1, reset  clock, asynchronous active-high reset
//   value, value_valid  binary sample and its single-cycle load strobe
//   seg, dp, an       active-low segments, decimal point, digit selects
//   busy              conversion in progress
//   overflow          committed value >= 10^N_DIGITS (display shows dashes)
module multi_digit_sensor_display
  import sensor_display_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int BIN_W       = 16,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1,
  parameter int DP_POS      = -1
) (
  input  logic                fpga_clk1,
  input  logic                reset,
  input  logic [BIN_W-1:0]    value,
  input  logic                value_valid,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [N_DIGITS-1:0] an,
  output logic                busy,
  output logic                overflow
);

  localparam int IDX_W       = $clog2(N_DIGITS);
  localparam int CNT_W       = $clog2(REFRESH_DIV);
  localparam int BLANK_FLOOR = (DP_POS > 0) ? DP_POS : 0;
  localparam bit DP_EN       = (DP_POS >= 0) && (DP_POS < N_DIGITS);
  localparam logic [IDX_W-1:0] DP_IDX = DP_EN ? IDX_W'(DP_POS) : '0;

  logic                       conv_busy;
  logic                       conv_done;
  logic                       conv_ovf;
  logic [N_DIGITS*4-1:0]      conv_bcd;
  logic                       launch;
  logic [BIN_W-1:0]           start_value;
  logic                       pend_valid;
  logic [BIN_W-1:0]           pend_value;
  logic [N_DIGITS-1:0][3:0]   digit_reg;
  logic [N_DIGITS-1:0]        blank;
  logic                       lead;
  logic [CNT_W-1:0]           refresh_cnt;
  logic [IDX_W-1:0]           scan_idx;

  // A fresh strobe while idle beats an older pending value.
  assign launch      = ~conv_busy & (value_valid | pend_valid);
  assign start_value = value_valid ? value : pend_value;
  assign busy        = conv_busy;

  bin_to_bcd_seq #(
    .N_DIGITS (N_DIGITS),
    .BIN_W    (BIN_W)
  ) u_conv (
    .clk   (fpga_clk1),
    .rst   (reset),
    .start (launch),
    .din   (start_value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  always_ff @(posedge fpga_clk1 or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_value <= '0;
    end else if (launch) begin
      pend_valid <= 1'b0;
    end else if (value_valid) begin
      pend_valid <= 1'b1;
      pend_value <= value;
    end
  end

  // Display registers only change on commit, so partial results never show.
  always_ff @(posedge fpga_clk1 or posedge reset) begin
    if (reset) begin
      digit_reg <= '0;
      overflow  <= 1'b0;
    end else if (conv_done) begin
      digit_reg <= conv_bcd;
      overflow  <= conv_ovf;
    end
  end

  // Walk down from the top digit; blanking stops at the first nonzero digit,
  // at digit 0, and at or below the decimal-point digit.
  always_comb begin
    blank = '0;
    lead  = 1'b1;
    for (int unsigned i = N_DIGITS; i > 0; i--) begin
      lead = lead & (digit_reg[i-1] == 4'd0);
      if ((BLANK_LZ != 0) && lead && ((i - 1) > BLANK_FLOOR))
        blank[i-1] = 1'b1;
    end
  end

  always_ff @(posedge fpga_clk1 or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
      an          <= '1;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
    end else begin
      if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        scan_idx    <= (scan_idx == IDX_W'(N_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
      end else begin
        refresh_cnt <= refresh_cnt + CNT_W'(1);
      end
      an <= ~(N_DIGITS'(1) << scan_idx);
      if (overflow) begin
        seg <= SEG_DASH;
        dp  <= 1'b1;
      end else begin
        seg <= blank[scan_idx] ? SEG_BLANK : seg_decode(digit_reg[scan_idx]);
        dp  <= !(DP_EN && (scan_idx == DP_IDX));
      end
    end
  end

endmodule

// File: tb/tb_multi_digit_sensor_display.sv
module tb_multi_digit_sensor_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b0111111;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        value_valid;

  logic [6:0] seg_a, seg_b, seg_c;
  logic       dp_a, dp_b, dp_c;
  logic [3:0] an_a, an_b, an_c;
  logic       busy_a, busy_b, busy_c;
  logic       ovf_a, ovf_b, ovf_c;

  int checks = 0;
  int errors = 0;

  logic [6:0] cap_seg [3][4];
  logic       cap_dp  [3][4];
  int         cap_cnt [3][4];
  logic       scan_ok;
  logic       hold_ok;

  always #5 clk = ~clk;

  multi_digit_sensor_display #(
    .N_DIGITS(4), .BIN_W(16), .REFRESH_DIV(4), .BLANK_LZ(1), .DP_POS(-1)
  ) dut_a (
    .fpga_clk1(clk), .reset(reset), .value(value), .value_valid(value_valid),
    .seg(seg_a), .dp(dp_a), .an(an_a), .busy(busy_a), .overflow(ovf_a)
  );

  multi_digit_sensor_display #(
    .N_DIGITS(4), .BIN_W(16), .REFRESH_DIV(4), .BLANK_LZ(0), .DP_POS(-1)
  ) dut_b (
    .fpga_clk1(clk), .reset(reset), .value(value), .value_valid(value_valid),
    .seg(seg_b), .dp(dp_b), .an(an_b), .busy(busy_b), .overflow(ovf_b)
  );

  multi_digit_sensor_display #(
    .N_DIGITS(4), .BIN_W(16), .REFRESH_DIV(4), .BLANK_LZ(1), .DP_POS(1)
  ) dut_c (
    .fpga_clk1(clk), .reset(reset), .value(value), .value_valid(value_valid),
    .seg(seg_c), .dp(dp_c), .an(an_c), .busy(busy_c), .overflow(ovf_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [15:0] v);
    @(negedge clk);
    value       = v;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Sample 16 consecutive cycles (one full scan period) of all three displays.
  task automatic scan();
    int         prev [3];
    int         idx;
    logic [3:0] a;
    logic [6:0] s;
    logic       d;
    scan_ok = 1'b1;
    hold_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      prev[k] = -1;
      for (int i = 0; i < 4; i++) begin
        cap_cnt[k][i] = 0;
        cap_seg[k][i] = 7'bx;
        cap_dp[k][i]  = 1'bx;
      end
    end
    repeat (16) begin
      for (int k = 0; k < 3; k++) begin
        case (k)
          0:       begin a = an_a; s = seg_a; d = dp_a; end
          1:       begin a = an_b; s = seg_b; d = dp_b; end
          default: begin a = an_c; s = seg_c; d = dp_c; end
        endcase
        if ($countones(~a) != 1) begin
          scan_ok = 1'b0;
        end else begin
          idx = 0;
          for (int i = 0; i < 4; i++) if (a[i] == 1'b0) idx = i;
          cap_seg[k][idx] = s;
          cap_dp[k][idx]  = d;
          cap_cnt[k][idx]++;
          if (prev[k] >= 0 && idx != prev[k] && idx != (prev[k] + 1) % 4) scan_ok = 1'b0;
          prev[k] = idx;
        end
      end
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++)
        if (cap_cnt[k][i] != 4) hold_ok = 1'b0;
  endtask

  task automatic check_disp(input string tag, input int k,
                            input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_d%0d", tag, i), 32'(cap_seg[k][i]), 32'(e[i]));
  endtask

  task automatic check_dp(input string tag, input logic [3:0] e);
    logic [3:0] obs;
    for (int i = 0; i < 4; i++) obs[i] = cap_dp[2][i];
    chk(tag, 32'(obs), 32'(e));
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    value       = '0;
    value_valid = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_an", 32'(an_a), 32'(4'b1111));
    chk("rst_seg", 32'(seg_a), 32'(SB));
    chk("rst_dp", 32'(dp_c), 32'(1'b1));
    chk("rst_busy", 32'(busy_a), 32'(1'b0));
    chk("rst_ovf", 32'(ovf_a), 32'(1'b0));
    reset = 1'b0;
    @(negedge clk);
    chk("first_an", 32'(an_a), 32'(4'b1110));
    chk("first_seg", 32'(seg_a), 32'(S0));

    // 2578: busy spans 17 cycles, then all four digits
    strobe(16'd2578);
    chk("busy_e0", 32'(busy_a), 32'(1'b1));
    wait_idle(n);
    chk("busy_len_2578", 32'(n), 32'(17));
    chk("ovf_2578", 32'(ovf_a), 32'(1'b0));
    @(negedge clk);
    scan();
    chk("scan_order", 32'(scan_ok), 32'(1'b1));
    chk("scan_hold", 32'(hold_ok), 32'(1'b1));
    check_disp("a2578", 0, S2, S5, S7, S8);
    check_disp("b2578", 1, S2, S5, S7, S8);
    check_disp("c2578", 2, S2, S5, S7, S8);
    check_dp("dp_2578", 4'b1101);
    chk("dp_a_2578", 32'(dp_a), 32'(1'b1));

    // 7: leading-zero blanking on/off, and stop at the dp digit
    strobe(16'd7);
    wait_idle(n);
    chk("busy_len_7", 32'(n), 32'(17));
    @(negedge clk);
    scan();
    check_disp("a7", 0, SB, SB, SB, S7);
    check_disp("b7", 1, S0, S0, S0, S7);
    check_disp("c7", 2, SB, SB, S0, S7);

    // 10000: overflow shows dashes, dp suppressed
    strobe(16'd10000);
    wait_idle(n);
    chk("ovf_10000", 32'(ovf_a), 32'(1'b1));
    @(negedge clk);
    scan();
    check_disp("a10000", 0, SD, SD, SD, SD);
    check_disp("b10000", 1, SD, SD, SD, SD);
    check_dp("dp_10000", 4'b1111);

    // 9999: largest in-range value
    strobe(16'd9999);
    wait_idle(n);
    chk("ovf_9999", 32'(ovf_a), 32'(1'b0));
    @(negedge clk);
    scan();
    check_disp("a9999", 0, S9, S9, S9, S9);

    // 100, 200, 300 in one busy window: 100 commits, then 300
    @(negedge clk);
    value = 16'd100; value_valid = 1'b1;
    @(negedge clk);
    value = 16'd200;
    @(negedge clk);
    value = 16'd300;
    @(negedge clk);
    value_valid = 1'b0;
    wait_idle(n);
    chk("busy_len_100", 32'(n), 32'(15));
    @(negedge clk);
    chk("busy_gap_one", 32'(busy_a), 32'(1'b1));
    scan();
    check_disp("a100", 0, SB, S1, S0, S0);
    wait_idle(n);
    chk("busy_300_ends", 32'(busy_a), 32'(1'b0));
    @(negedge clk);
    scan();
    check_disp("a300", 0, SB, S3, S0, S0);

    // Reset at E8 of converting 1234 aborts it
    strobe(16'd1234);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy_a), 32'(1'b0));
    repeat (20) @(negedge clk);
    chk("abort_busy_late", 32'(busy_a), 32'(1'b0));
    scan();
    check_disp("a_abort", 0, SB, SB, SB, S0);
    strobe(16'd42);
    wait_idle(n);
    chk("busy_len_42", 32'(n), 32'(17));
    @(negedge clk);
    scan();
    check_disp("a42", 0, SB, SB, S4, S2);

    // 5 with DP_POS=1 shows "0.5"
    strobe(16'd5);
    wait_idle(n);
    @(negedge clk);
    scan();
    chk("scan_hold_5", 32'(hold_ok), 32'(1'b1));
    check_disp("c5", 2, SB, SB, S0, S5);
    check_dp("dp_5", 4'b1101);
    check_disp("a5", 0, SB, SB, SB, S5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
